fifo_uart_tx_reader: RTL

Read-side consumer of the asynchronous FIFO. Runs in the FIFO read-clock domain, pops one word when the FIFO is non-empty and the block is idle, and serialises it as a UART frame (start bit, data LSB first, optional parity, stop bit), one bit per CLK cycle. It pairs with the FIFO writer on the other clock domain to complete the outbound data path.

---
 rtl/fifo_uart_tx_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx_reader.sv
// Read-side FIFO consumer: pops one word whenever idle (or finishing a stop bit)
// and serialises it as a UART frame, one bit per clock, with optional parity.
module fifo_uart_tx_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_r_inc,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_par_en;
  logic                  w_par_en_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  w_load;

  // The pop strobe doubles as the load enable, so FIFO pointer and shift register move together.
  assign w_load  = !i_empty && ((r_state == S_IDLE) || (r_state == S_STOP)) && !i_rst;
  assign o_r_inc = w_load;
  assign o_tx_out = r_tx;
  assign o_busy   = r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_cnt    <= w_cnt_nxt;
      r_par_en <= w_par_en_nxt;
      r_par    <= w_par_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    w_par_en_nxt = r_par_en;
    w_par_nxt    = r_par;

    case (r_state)
      S_IDLE, S_STOP: begin
        if (w_load) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = i_rd_data;
          w_par_en_nxt = i_par_en;
          w_par_nxt    = (^i_rd_data) ^ i_par_typ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_state_nxt = S_DATA;
        w_cnt_nxt   = '0;
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
        end else begin
          w_shift_nxt = r_shift >> 1;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_PARITY: w_state_nxt = S_STOP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Line outputs are registered from the upcoming state so they line up with r_state.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:   w_busy_nxt = 1'b0;
      S_START:  w_tx_nxt   = 1'b0;
      S_DATA:   w_tx_nxt   = w_shift_nxt[0];
      S_PARITY: w_tx_nxt   = w_par_nxt;
      S_STOP:   w_tx_nxt   = 1'b1;
      default: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

endmodule
